gtp_block_writer: RTL and testbench

//  Collects 16-bit data from the 4 GTP receiver lanes and packs it into 32-bit words in per-lane FIFOs.

---
 rtl/gtp_writer_pkg.sv | 37 +++
 rtl/lane_fifo.sv | 57 +++++
 rtl/gtp_block_writer.sv | 199 +++++++++++++++++++
 tb/tb_gtp_block_writer.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gtp_writer_pkg.sv
// gtp_writer_pkg: shared state encoding, MCB
// constants, status layout and rr arbiter helper.
package gtp_writer_pkg;

  localparam int NLANES = 4;

  localparam logic [2:0] MCB_WRITE_AP = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_CMD  = 2'd2
  } state_t;

  localparam int STS_OVF = 0;
  localparam int STS_NE  = 4;
  localparam int STS_ST  = 8;
  localparam int STS_EN  = 11;
  localparam int STS_BLK = 16;

  // Returns {found, lane}: first eligible lane
  // scanning rr, rr+1, ... modulo NLANES.
  function automatic logic [2:0] rr_pick(
    input logic [NLANES-1:0] elig,
    input logic [1:0]        rr
  );
    logic [1:0] idx;
    logic [2:0] res;
    res = 3'b000;
    for (int k = NLANES - 1; k >= 0; k--) begin
      idx = rr + 2'(k);
      if (elig[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

endpackage

// File: rtl/lane_fifo.sv
// lane_fifo: FWFT FIFO with occupancy count.
// Ports: i_push/i_din in, i_pop/o_dout out, o_count/o_full/o_empty.
module lane_fifo #(
  parameter int DW    = 32,
  parameter int DEPTH = 64
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_push,
  input  logic [DW-1:0]            i_din,
  input  logic                     i_pop,
  output logic [DW-1:0]            o_dout,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wp;
  logic [AW-1:0] r_rp;
  logic [AW:0]   r_cnt;
  logic          w_wr;
  logic          w_rd;

  assign o_empty = (r_cnt == '0);
  assign o_full  = (r_cnt == (AW+1)'(DEPTH));
  assign o_count = r_cnt;
  assign o_dout  = r_mem[r_rp];

  // A pop frees a slot in the same cycle,
  // so a full FIFO still accepts push+pop.
  assign w_rd = i_pop & ~o_empty;
  assign w_wr = i_push & (~o_full | w_rd);

  always_ff @(posedge i_clk) begin
    if (w_wr) r_mem[r_wp] <= i_din;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_wr) r_wp <= r_wp + 1'b1;
      if (w_rd) r_rp <= r_rp + 1'b1;
      unique case ({w_wr, w_rd})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/gtp_block_writer.sv
// gtp_block_writer: packs 4 GTP lanes into 32b words, moves
// full blocks to MCB port 2 into a circular SDRAM buffer.
// Ports: wb_clk/wb_rst_n, gtp_dat/gtp_vld, enable, clr_ovf,
// p2_cmd_*/p2_wr_* MCB port 2, wr_ptr, status.
module gtp_block_writer
  import gtp_writer_pkg::*;
#(
  parameter int          BLOCK_LEN  = 16,
  parameter int          FIFO_DEPTH = 64,
  parameter logic [28:0] BUF_BASE   = 29'h0000000,
  parameter logic [28:0] BUF_SIZE   = 29'h10000000
) (
  input  logic        wb_clk,
  input  logic        wb_rst_n,
  input  logic [63:0] gtp_dat,
  input  logic [3:0]  gtp_vld,
  input  logic        enable,
  input  logic        clr_ovf,
  output logic        p2_cmd_en,
  output logic [2:0]  p2_cmd_instr,
  output logic [5:0]  p2_cmd_bl,
  output logic [29:0] p2_cmd_byte_addr,
  input  logic        p2_cmd_full,
  output logic        p2_wr_en,
  output logic [31:0] p2_wr_data,
  output logic [3:0]  p2_wr_mask,
  input  logic        p2_wr_full,
  output logic [28:0] wr_ptr,
  output logic [31:0] status
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] ELIG = CW'(BLOCK_LEN);
  localparam logic [5:0] WC_LAST = 6'(BLOCK_LEN - 1);
  localparam logic [29:0] BLK_BYTES = 30'(BLOCK_LEN * 4);
  localparam logic [29:0] BUF_END =
    {1'b0, BUF_BASE} + {1'b0, BUF_SIZE};

  state_t r_st;
  state_t w_nxt;

  logic [NLANES-1:0] r_has;
  logic [NLANES-1:0] r_pv;
  logic [NLANES-1:0] r_ovf;
  logic [NLANES-1:0] w_push;
  logic [NLANES-1:0] w_pop;
  logic [NLANES-1:0] w_full;
  logic [NLANES-1:0] w_empty;
  logic [NLANES-1:0] w_elig;
  logic [NLANES-1:0] w_ovf_set;

  logic [15:0]   r_lo   [NLANES];
  logic [31:0]   r_wd   [NLANES];
  logic [31:0]   w_head [NLANES];
  logic [CW-1:0] w_cnt  [NLANES];

  logic [1:0]  r_grant;
  logic [1:0]  r_rr;
  logic [2:0]  w_arb;
  logic [5:0]  r_wcnt;
  logic [28:0] r_ptr;
  logic [29:0] w_ptr_sum;
  logic [28:0] w_ptr_nxt;
  logic [15:0] r_blk;
  logic        r_en;
  logic        w_grant_ld;
  logic        w_wr_en;
  logic        w_cmd_en;

  for (genvar g = 0; g < NLANES; g++) begin : g_lane
    // A completed word is held one cycle; it is
    // dropped if enable has gone low by then.
    assign w_push[g]    = r_pv[g] & enable;
    assign w_pop[g]     = w_wr_en & (r_grant == 2'(g));
    assign w_elig[g]    = (w_cnt[g] >= ELIG);
    assign w_ovf_set[g] = w_push[g] & w_full[g] & ~w_pop[g];

    lane_fifo #(
      .DW    (32),
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .i_clk   (wb_clk),
      .i_rst_n (wb_rst_n),
      .i_push  (w_push[g]),
      .i_din   (r_wd[g]),
      .i_pop   (w_pop[g]),
      .o_dout  (w_head[g]),
      .o_count (w_cnt[g]),
      .o_full  (w_full[g]),
      .o_empty (w_empty[g])
    );
  end

  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      r_has <= '0;
      r_pv  <= '0;
      for (int i = 0; i < NLANES; i++) begin
        r_lo[i] <= '0;
        r_wd[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NLANES; i++) begin
        r_pv[i] <= 1'b0;
        if (!enable) begin
          r_has[i] <= 1'b0;
        end else if (gtp_vld[i]) begin
          if (r_has[i]) begin
            r_wd[i]  <= {gtp_dat[16*i +: 16], r_lo[i]};
            r_pv[i]  <= 1'b1;
            r_has[i] <= 1'b0;
          end else begin
            r_lo[i]  <= gtp_dat[16*i +: 16];
            r_has[i] <= 1'b1;
          end
        end
      end
    end
  end

  assign w_arb = rr_pick(w_elig, r_rr);

  always_comb begin
    w_nxt      = r_st;
    w_grant_ld = 1'b0;
    w_wr_en    = 1'b0;
    w_cmd_en   = 1'b0;
    unique case (r_st)
      ST_IDLE: begin
        if (w_arb[2]) begin
          w_grant_ld = 1'b1;
          w_nxt      = ST_XFER;
        end
      end
      ST_XFER: begin
        w_wr_en = ~p2_wr_full;
        if (w_wr_en && r_wcnt == WC_LAST)
          w_nxt = ST_CMD;
      end
      ST_CMD: begin
        w_cmd_en = ~p2_cmd_full;
        if (w_cmd_en) w_nxt = ST_IDLE;
      end
      default: w_nxt = ST_IDLE;
    endcase
  end

  assign w_ptr_sum = {1'b0, r_ptr} + BLK_BYTES;
  assign w_ptr_nxt = (w_ptr_sum == BUF_END) ?
                     BUF_BASE : w_ptr_sum[28:0];

  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      r_st    <= ST_IDLE;
      r_grant <= '0;
      r_rr    <= '0;
      r_wcnt  <= '0;
      r_ptr   <= BUF_BASE;
      r_blk   <= '0;
      r_ovf   <= '0;
      r_en    <= 1'b0;
    end else begin
      r_st  <= w_nxt;
      r_en  <= enable;
      r_ovf <= (r_ovf & ~{NLANES{clr_ovf}}) | w_ovf_set;
      if (w_grant_ld) begin
        r_grant <= w_arb[1:0];
        r_rr    <= w_arb[1:0] + 2'd1;
        r_wcnt  <= '0;
      end
      if (w_wr_en) r_wcnt <= r_wcnt + 6'd1;
      if (w_cmd_en) begin
        r_ptr <= w_ptr_nxt;
        r_blk <= r_blk + 16'd1;
      end
    end
  end

  assign p2_cmd_en        = w_cmd_en;
  assign p2_cmd_instr     = MCB_WRITE_AP;
  assign p2_cmd_bl        = (r_st == ST_CMD) ? WC_LAST : '0;
  assign p2_cmd_byte_addr = (r_st == ST_CMD) ?
                            {1'b0, r_ptr} : '0;
  assign p2_wr_en         = w_wr_en;
  assign p2_wr_data       = (r_st == ST_XFER) ?
                            w_head[r_grant] : '0;
  assign p2_wr_mask       = 4'b0000;
  assign wr_ptr           = r_ptr;

  always_comb begin
    status                  = '0;
    status[STS_OVF +: 4]    = r_ovf;
    status[STS_NE +: 4]     = ~w_empty;
    status[STS_ST +: 2]     = r_st;
    status[STS_EN]          = r_en;
    status[STS_BLK +: 16]   = r_blk;
  end

endmodule

// File: tb/tb_gtp_block_writer.sv
// tb_gtp_block_writer: directed stimulus, queue-based
// reference model and per-cycle output comparison.
module tb_gtp_block_writer;

  localparam int BL    = 16;
  localparam int DEPTH = 64;

  logic        wb_clk = 1'b0;
  logic        wb_rst_n = 1'b0;
  logic [63:0] gtp_dat = '0;
  logic [3:0]  gtp_vld = '0;
  logic        enable = 1'b0;
  logic        clr_ovf = 1'b0;
  logic        p2_cmd_full = 1'b0;
  logic        p2_wr_full = 1'b0;

  logic        p2_cmd_en;
  logic [2:0]  p2_cmd_instr;
  logic [5:0]  p2_cmd_bl;
  logic [29:0] p2_cmd_byte_addr;
  logic        p2_wr_en;
  logic [31:0] p2_wr_data;
  logic [3:0]  p2_wr_mask;
  logic [28:0] wr_ptr;
  logic [31:0] status;

  logic        w_cmd_en;
  logic [2:0]  w_cmd_instr;
  logic [5:0]  w_cmd_bl;
  logic [29:0] w_cmd_addr;
  logic        w_wr_en;
  logic [31:0] w_wr_data;
  logic [3:0]  w_wr_mask;
  logic [28:0] w_wr_ptr;
  logic [31:0] w_status;

  always #5 wb_clk = ~wb_clk;

  gtp_block_writer u_dut (
    .wb_clk           (wb_clk),
    .wb_rst_n         (wb_rst_n),
    .gtp_dat          (gtp_dat),
    .gtp_vld          (gtp_vld),
    .enable           (enable),
    .clr_ovf          (clr_ovf),
    .p2_cmd_en        (p2_cmd_en),
    .p2_cmd_instr     (p2_cmd_instr),
    .p2_cmd_bl        (p2_cmd_bl),
    .p2_cmd_byte_addr (p2_cmd_byte_addr),
    .p2_cmd_full      (p2_cmd_full),
    .p2_wr_en         (p2_wr_en),
    .p2_wr_data       (p2_wr_data),
    .p2_wr_mask       (p2_wr_mask),
    .p2_wr_full       (p2_wr_full),
    .wr_ptr           (wr_ptr),
    .status           (status)
  );

  gtp_block_writer #(.BUF_SIZE(29'h80)) u_wrap (
    .wb_clk           (wb_clk),
    .wb_rst_n         (wb_rst_n),
    .gtp_dat          (gtp_dat),
    .gtp_vld          (gtp_vld),
    .enable           (enable),
    .clr_ovf          (clr_ovf),
    .p2_cmd_en        (w_cmd_en),
    .p2_cmd_instr     (w_cmd_instr),
    .p2_cmd_bl        (w_cmd_bl),
    .p2_cmd_byte_addr (w_cmd_addr),
    .p2_cmd_full      (p2_cmd_full),
    .p2_wr_en         (w_wr_en),
    .p2_wr_data       (w_wr_data),
    .p2_wr_mask       (w_wr_mask),
    .p2_wr_full       (p2_wr_full),
    .wr_ptr           (w_wr_ptr),
    .status           (w_status)
  );

  int total = 0;
  int bad = 0;

  logic [31:0] m_q [4][$];
  logic [15:0] m_lo [4];
  bit   [3:0]  m_has;
  logic [3:0]  m_ovf;
  int          seq [4];
  int          m_rr, m_lane, m_inblk, m_blk;
  logic [28:0] m_ptr, m_wptr;
  logic [31:0] wlog [$];
  logic [29:0] clog [$];
  logic [29:0] wclog [$];
  int          glog [$];

  task automatic chk(input string nm,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, got, exp);
    end
  endtask

  function automatic logic [28:0] adv(
    input logic [28:0] p, input logic [29:0] size);
    logic [29:0] n;
    n = {1'b0, p} + 30'd64;
    if (n == size) return 29'h0;
    return n[28:0];
  endfunction

  function automatic int predict();
    int l;
    for (int k = 0; k < 4; k++) begin
      l = (m_rr + k) % 4;
      if (m_q[l].size() >= BL) return l;
    end
    return -1;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 4; i++) begin
      m_q[i].delete();
      m_lo[i] = '0;
      seq[i] = 0;
    end
    m_has = '0;
    m_ovf = '0;
    m_rr = 0;
    m_lane = 0;
    m_inblk = 0;
    m_blk = 0;
    m_ptr = '0;
    m_wptr = '0;
    wlog.delete();
    clog.delete();
    wclog.delete();
    glog.delete();
  endtask

  task automatic model_hw(input int i, input logic [15:0] hw);
    if (m_has[i]) begin
      m_has[i] = 1'b0;
      if (m_q[i].size() < DEPTH)
        m_q[i].push_back({hw, m_lo[i]});
      else
        m_ovf[i] = 1'b1;
    end else begin
      m_lo[i] = hw;
      m_has[i] = 1'b1;
    end
  endtask

  always @(negedge wb_clk) begin
    int l;
    if (wb_rst_n) begin
      chk("wr_ptr", wr_ptr, m_ptr);
      chk("wrap_ptr", w_wr_ptr, m_wptr);
      chk("blk_cnt", status[31:16], 16'(m_blk));
      chk("wrap_wr_en", w_wr_en, p2_wr_en);
      if (p2_wr_full) chk("stall", p2_wr_en, 1'b0);
      if (p2_cmd_full) chk("cmd_hold", p2_cmd_en, 1'b0);
      if (p2_wr_en) begin
        if (m_inblk == 0) begin
          l = predict();
          if (l < 0) begin
            total++;
            bad++;
            $display("FAIL grant got=lane%0d want=none",
                     p2_wr_data[15:14]);
            l = int'(p2_wr_data[15:14]);
          end
          m_lane = l;
          m_rr = (l + 1) % 4;
          glog.push_back(l);
        end
        if (m_inblk >= BL) chk("overrun", m_inblk, BL - 1);
        if (m_q[m_lane].size() == 0)
          chk("underrun", p2_wr_data, 32'hxxxxxxxx);
        else
          chk("wdata", p2_wr_data, m_q[m_lane].pop_front());
        wlog.push_back(p2_wr_data);
        m_inblk++;
      end
      if (p2_cmd_en) begin
        chk("cmd_words", m_inblk, BL);
        chk("cmd_addr", p2_cmd_byte_addr, {1'b0, m_ptr});
        chk("cmd_bl", p2_cmd_bl, BL - 1);
        chk("cmd_instr", p2_cmd_instr, 3'b010);
        clog.push_back(p2_cmd_byte_addr);
        m_ptr = adv(m_ptr, 30'h10000000);
        m_blk++;
        m_inblk = 0;
      end
      chk("wrap_cmd_en", w_cmd_en, p2_cmd_en);
      if (w_cmd_en) begin
        chk("wrap_addr", w_cmd_addr, {1'b0, m_wptr});
        wclog.push_back(w_cmd_addr);
        m_wptr = adv(m_wptr, 30'h80);
      end
    end
  end

  task automatic drive(input logic [3:0] mask);
    logic [15:0] hw;
    @(posedge wb_clk);
    #1;
    gtp_vld = mask;
    for (int i = 0; i < 4; i++) begin
      hw = {2'(i), 14'(seq[i])};
      if (mask[i]) begin
        gtp_dat[16*i +: 16] = hw;
        model_hw(i, hw);
        seq[i]++;
      end else begin
        gtp_dat[16*i +: 16] = '0;
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge wb_clk);
      #1;
      gtp_vld = '0;
      gtp_dat = '0;
    end
  endtask

  task automatic wait_blocks(input int n, input int lim);
    int t = 0;
    while (m_blk < n && t < lim) begin
      @(posedge wb_clk);
      #1;
      gtp_vld = '0;
      t++;
    end
    chk("wait_blocks", m_blk, n);
  endtask

  task automatic wait_words(input int n, input int lim);
    int t = 0;
    while (wlog.size() < n && t < lim) begin
      @(posedge wb_clk);
      #1;
      gtp_vld = '0;
      t++;
    end
    chk("wait_words", wlog.size() >= n, 1'b1);
  endtask

  task automatic do_reset();
    wb_rst_n = 1'b0;
    gtp_vld = '0;
    gtp_dat = '0;
    enable = 1'b0;
    clr_ovf = 1'b0;
    p2_cmd_full = 1'b0;
    p2_wr_full = 1'b0;
    model_clear();
    repeat (2) @(posedge wb_clk);
    #1;
    chk("rst_cmd_en", p2_cmd_en, 1'b0);
    chk("rst_wr_en", p2_wr_en, 1'b0);
    chk("rst_ptr", wr_ptr, 29'h0);
    chk("rst_status", status, 32'h0);
    chk("rst_instr", p2_cmd_instr, 3'b010);
    chk("rst_addr", p2_cmd_byte_addr, 30'h0);
    chk("rst_wdata", p2_wr_data, 32'h0);
    wb_rst_n = 1'b1;
    enable = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1);
  end

  initial begin
    int nw;

    do_reset();
    repeat (32) drive(4'b0001);
    wait_blocks(1, 200);
    chk("t1_words", wlog.size(), 16);
    if (wlog.size() >= 16) begin
      chk("t1_w0", wlog[0], 32'h00010000);
      chk("t1_w1", wlog[1], 32'h00030002);
      chk("t1_w15", wlog[15], 32'h001F001E);
    end
    if (clog.size() >= 1) chk("t1_addr", clog[0], 30'h0);
    chk("t1_ptr", wr_ptr, 29'h40);

    do_reset();
    repeat (32) drive(4'b1111);
    wait_blocks(4, 400);
    chk("t2_blocks", status[31:16], 16'd4);
    chk("t2_ng", glog.size(), 4);
    if (glog.size() >= 4) begin
      for (int k = 0; k < 4; k++) begin
        chk("t2_grant", glog[k], k);
        chk("t2_addr", clog[k], 30'(k * 64));
      end
    end
    repeat (32) drive(4'b1001);
    wait_blocks(6, 400);
    if (glog.size() >= 6) begin
      chk("t2_rr0", glog[4], 0);
      chk("t2_rr1", glog[5], 3);
    end

    do_reset();
    repeat (32) drive(4'b0001);
    wait_words(4, 200);
    p2_wr_full = 1'b1;
    p2_cmd_full = 1'b1;
    nw = wlog.size();
    repeat (5) begin
      @(posedge wb_clk);
      #1;
    end
    chk("t3_stall", wlog.size(), nw);
    p2_wr_full = 1'b0;
    wait_words(16, 200);
    repeat (10) begin
      @(posedge wb_clk);
      #1;
    end
    chk("t3_nocmd", clog.size(), 0);
    p2_cmd_full = 1'b0;
    wait_blocks(1, 100);
    idle(20);
    chk("t3_onecmd", clog.size(), 1);
    chk("t3_words", wlog.size(), 16);
    if (wlog.size() >= 5) chk("t3_w4", wlog[4], 32'h00090008);

    do_reset();
    p2_wr_full = 1'b1;
    repeat (140) drive(4'b0100);
    idle(3);
    chk("t4_ovf", status[3:0], 4'b0100);
    chk("t4_movf", status[3:0], m_ovf);
    chk("t4_ne", status[6], 1'b1);
    chk("t4_none", wlog.size(), 0);
    p2_wr_full = 1'b0;
    wait_blocks(4, 400);
    idle(5);
    chk("t4_words", wlog.size(), 64);
    if (wlog.size() >= 64) begin
      chk("t4_w0", wlog[0], 32'h80018000);
      chk("t4_w63", wlog[63], 32'h807F807E);
    end
    chk("t4_empty", status[6], 1'b0);
    chk("t4_sticky", status[2], 1'b1);
    clr_ovf = 1'b1;
    @(posedge wb_clk);
    #1;
    clr_ovf = 1'b0;
    chk("t4_clr", status[3:0], 4'b0000);

    do_reset();
    repeat (96) drive(4'b0001);
    wait_blocks(3, 600);
    chk("t5_n", wclog.size(), 3);
    if (wclog.size() >= 3) begin
      chk("t5_a0", wclog[0], 30'h00);
      chk("t5_a1", wclog[1], 30'h40);
      chk("t5_a2", wclog[2], 30'h00);
    end
    chk("t5_wptr", w_wr_ptr, 29'h40);
    repeat (32) drive(4'b0001);
    wait_words(51, 300);
    chk("t5_xfer", status[9:8], 2'd1);
    #2;
    wb_rst_n = 1'b0;
    model_clear();
    #1;
    chk("t5_rst_wen", p2_wr_en, 1'b0);
    chk("t5_rst_cmd", p2_cmd_en, 1'b0);
    chk("t5_rst_ptr", wr_ptr, 29'h0);
    chk("t5_rst_wptr", w_wr_ptr, 29'h0);
    chk("t5_rst_sts", status, 32'h0);
    chk("t5_rst_wd", p2_wr_data, 32'h0);
    @(posedge wb_clk);
    #1;
    wb_rst_n = 1'b1;

    do_reset();
    drive(4'b0010);
    idle(2);
    enable = 1'b0;
    m_has = '0;
    idle(1);
    enable = 1'b1;
    repeat (32) drive(4'b0010);
    wait_blocks(1, 200);
    if (wlog.size() >= 1) chk("t6_w0", wlog[0], 32'h40024001);
    idle(3);
    chk("t6_empty", status[5], 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
